// File: rtl/osnt_monitor_pkg.sv
// Shared definitions for the osnt_monitor datapath: drop-FIFO write states
// and the geometry of a stored AXI-Stream beat.
package osnt_monitor_pkg;

  typedef enum logic {
    STORE = 1'b0,
    DROP  = 1'b1
  } fifo_state_t;

  localparam int DATA_WIDTH  = 256;
  localparam int TUSER_WIDTH = 128;
  localparam int ADDR_WIDTH  = 6;
  localparam int DEPTH       = 2 ** ADDR_WIDTH;

  // One entry is {tlast, tuser, tstrb, tdata}.
  function automatic int entry_width(input int data_w, input int tuser_w);
    return data_w + data_w / 8 + tuser_w + 1;
  endfunction

  localparam int ENTRY_WIDTH = entry_width(DATA_WIDTH, TUSER_WIDTH);

endpackage

// File: rtl/nf10_packet_drop_fifo_ram.sv
// Simple dual-port buffer memory: synchronous write, combinational read so the
// output register can load a word in the same cycle it is addressed.
module nf10_packet_drop_fifo_ram
  import osnt_monitor_pkg::*;
#(
  parameter int WIDTH = ENTRY_WIDTH,
  parameter int AW    = ADDR_WIDTH
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/nf10_packet_drop_fifo.sv
// Store-and-forward packet buffer: only whole packets are released downstream,
// and a packet that does not fit is discarded in its entirety and counted.
module nf10_packet_drop_fifo
  import osnt_monitor_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int ADDR_WIDTH           = 6,
  parameter int COUNTER_WIDTH        = 32
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESETN,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    S_AXIS_TDATA,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  S_AXIS_TSTRB,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   S_AXIS_TUSER,
  input  logic                              S_AXIS_TVALID,
  input  logic                              S_AXIS_TLAST,
  output logic                              S_AXIS_TREADY,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]    M_AXIS_TDATA,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  M_AXIS_TSTRB,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   M_AXIS_TUSER,
  output logic                              M_AXIS_TVALID,
  output logic                              M_AXIS_TLAST,
  input  logic                              M_AXIS_TREADY,
  input  logic                              CLEAR_COUNTERS,
  output logic [COUNTER_WIDTH-1:0]          PKT_STORED_CNT,
  output logic [COUNTER_WIDTH-1:0]          PKT_DROPPED_CNT,
  output logic [ADDR_WIDTH:0]               FIFO_WORDS
);

  localparam int DW = C_S_AXIS_DATA_WIDTH;
  localparam int SW = C_S_AXIS_DATA_WIDTH / 8;
  localparam int UW = C_S_AXIS_TUSER_WIDTH;
  localparam int EW = entry_width(DW, UW);

  fifo_state_t               state_reg;
  logic [ADDR_WIDTH-1:0]     wr_ptr_reg;
  logic [ADDR_WIDTH-1:0]     commit_ptr_reg;
  logic [ADDR_WIDTH-1:0]     rd_ptr_reg;
  logic [ADDR_WIDTH-1:0]     wr_ptr_next;
  logic [ADDR_WIDTH-1:0]     fifo_words;
  logic [COUNTER_WIDTH-1:0]  stored_cnt_reg;
  logic [COUNTER_WIDTH-1:0]  dropped_cnt_reg;
  logic                      tready_reg;
  logic                      m_valid_reg;
  logic [EW-1:0]             wr_entry;
  logic [EW-1:0]             rd_entry;
  logic                      accept;
  logic                      full;
  logic                      wr_en;
  logic                      store_last;
  logic                      drop_last;
  logic                      out_load;

  assign accept      = S_AXIS_TVALID && tready_reg;
  assign wr_ptr_next = wr_ptr_reg + ADDR_WIDTH'(1);
  // One slot stays empty so full and empty remain distinguishable.
  assign full        = (wr_ptr_next == rd_ptr_reg);
  assign wr_en       = accept && (state_reg == STORE) && !full;
  assign store_last  = wr_en && S_AXIS_TLAST;
  assign drop_last   = accept && S_AXIS_TLAST && ((state_reg == DROP) || full);
  assign wr_entry    = {S_AXIS_TLAST, S_AXIS_TUSER, S_AXIS_TSTRB, S_AXIS_TDATA};

  nf10_packet_drop_fifo_ram #(
    .WIDTH (EW),
    .AW    (ADDR_WIDTH)
  ) u_ram (
    .clk   (S_AXI_ACLK),
    .we    (wr_en),
    .waddr (wr_ptr_reg),
    .wdata (wr_entry),
    .raddr (rd_ptr_reg),
    .rdata (rd_entry)
  );

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_reg      <= STORE;
      wr_ptr_reg     <= '0;
      commit_ptr_reg <= '0;
      tready_reg     <= 1'b0;
    end else begin
      tready_reg <= 1'b1;
      if (accept) begin
        unique case (state_reg)
          STORE: begin
            if (full) begin
              // Rewind over the partial packet; a non-final beat means the
              // remainder must be swallowed too.
              wr_ptr_reg <= commit_ptr_reg;
              if (!S_AXIS_TLAST) begin
                state_reg <= DROP;
              end
            end else begin
              wr_ptr_reg <= wr_ptr_next;
              if (S_AXIS_TLAST) begin
                commit_ptr_reg <= wr_ptr_next;
              end
            end
          end
          DROP: begin
            if (S_AXIS_TLAST) begin
              state_reg <= STORE;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      stored_cnt_reg  <= '0;
      dropped_cnt_reg <= '0;
    end else if (CLEAR_COUNTERS) begin
      stored_cnt_reg  <= '0;
      dropped_cnt_reg <= '0;
    end else begin
      if (store_last) stored_cnt_reg  <= stored_cnt_reg + COUNTER_WIDTH'(1);
      if (drop_last)  dropped_cnt_reg <= dropped_cnt_reg + COUNTER_WIDTH'(1);
    end
  end

  assign out_load = (!m_valid_reg || M_AXIS_TREADY) && (rd_ptr_reg != commit_ptr_reg);

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rd_ptr_reg   <= '0;
      m_valid_reg  <= 1'b0;
      M_AXIS_TDATA <= '0;
      M_AXIS_TSTRB <= '0;
      M_AXIS_TUSER <= '0;
      M_AXIS_TLAST <= 1'b0;
    end else if (out_load) begin
      rd_ptr_reg   <= rd_ptr_reg + ADDR_WIDTH'(1);
      m_valid_reg  <= 1'b1;
      M_AXIS_TDATA <= rd_entry[DW-1:0];
      M_AXIS_TSTRB <= rd_entry[DW+SW-1:DW];
      M_AXIS_TUSER <= rd_entry[DW+SW+UW-1:DW+SW];
      M_AXIS_TLAST <= rd_entry[EW-1];
    end else if (M_AXIS_TREADY) begin
      m_valid_reg <= 1'b0;
    end
  end

  assign fifo_words      = commit_ptr_reg - rd_ptr_reg;
  assign FIFO_WORDS      = {1'b0, fifo_words};
  assign S_AXIS_TREADY   = tready_reg;
  assign M_AXIS_TVALID   = m_valid_reg;
  assign PKT_STORED_CNT  = stored_cnt_reg;
  assign PKT_DROPPED_CNT = dropped_cnt_reg;

endmodule

// File: tb/tb_nf10_packet_drop_fifo.sv
// Randomized bench for nf10_packet_drop_fifo against a queue-based model of
// buffer occupancy, whole-packet commit/drop and the single output register.
module tb_nf10_packet_drop_fifo;

  localparam int DEPTH = 64;

  typedef struct packed {
    logic         last;
    logic [127:0] user;
    logic [31:0]  strb;
    logic [255:0] data;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [255:0] s_tdata;
  logic [31:0]  s_tstrb;
  logic [127:0] s_tuser;
  logic         s_tvalid;
  logic         s_tlast;
  logic         s_tready;
  logic [255:0] m_tdata;
  logic [31:0]  m_tstrb;
  logic [127:0] m_tuser;
  logic         m_tvalid;
  logic         m_tlast;
  logic         m_tready;
  logic         clear_counters;
  logic [31:0]  stored_cnt;
  logic [31:0]  dropped_cnt;
  logic [6:0]   fifo_words;

  always #5 clk = ~clk;

  nf10_packet_drop_fifo dut (
    .S_AXI_ACLK      (clk),
    .S_AXI_ARESETN   (rst_n),
    .S_AXIS_TDATA    (s_tdata),
    .S_AXIS_TSTRB    (s_tstrb),
    .S_AXIS_TUSER    (s_tuser),
    .S_AXIS_TVALID   (s_tvalid),
    .S_AXIS_TLAST    (s_tlast),
    .S_AXIS_TREADY   (s_tready),
    .M_AXIS_TDATA    (m_tdata),
    .M_AXIS_TSTRB    (m_tstrb),
    .M_AXIS_TUSER    (m_tuser),
    .M_AXIS_TVALID   (m_tvalid),
    .M_AXIS_TLAST    (m_tlast),
    .M_AXIS_TREADY   (m_tready),
    .CLEAR_COUNTERS  (clear_counters),
    .PKT_STORED_CNT  (stored_cnt),
    .PKT_DROPPED_CNT (dropped_cnt),
    .FIFO_WORDS      (fifo_words)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int out_beats;
  logic toggle_rdy = 1'b0;

  // Reference model: committed words still in the buffer, the packet being
  // assembled, the expected output stream and the statistics.
  beat_t       exp_q[$];
  beat_t       m_pending[$];
  int          m_committed;
  logic        m_dropping;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_stored;
  logic [31:0] m_dropped;

  function automatic beat_t cur_out();
    beat_t b;
    b = {m_tlast, m_tuser, m_tstrb, m_tdata};
    return b;
  endfunction

  function automatic beat_t mk_beat(input int idx, input int len, input logic [127:0] user);
    beat_t b;
    for (int k = 0; k < 8; k++) b.data[k*32 +: 32] = $urandom;
    b.strb = $urandom;
    b.user = user;
    b.last = (idx == len - 1);
    return b;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_pending.delete();
    m_committed = 0;
    m_dropping  = 1'b0;
    m_valid     = 1'b0;
    m_ready     = 1'b0;
    m_stored    = '0;
    m_dropped   = '0;
  endtask

  // One clock: drive at negedge, sample before the edge, model the edge,
  // then check everything at the following negedge.
  task automatic step(input logic v, input beat_t b, input logic rdy, input logic clr);
    beat_t pre, exp_b;
    logic  tv, acc, full;
    int    st_inc, dr_inc;
    s_tvalid = v; s_tdata = b.data; s_tstrb = b.strb; s_tuser = b.user; s_tlast = b.last;
    m_tready = rdy; clear_counters = clr;
    #1;
    tv  = m_tvalid;
    pre = cur_out();
    @(posedge clk);
    acc  = v && m_ready;
    full = (m_committed + m_pending.size()) == DEPTH - 1;
    if (!m_valid || rdy) begin
      if (m_committed > 0) begin
        m_valid = 1'b1;
        m_committed--;
      end else begin
        m_valid = 1'b0;
      end
    end
    st_inc = 0; dr_inc = 0;
    if (acc) begin
      if (m_dropping) begin
        if (b.last) begin dr_inc = 1; m_dropping = 1'b0; end
      end else if (full) begin
        m_pending.delete();
        if (b.last) dr_inc = 1; else m_dropping = 1'b1;
      end else begin
        m_pending.push_back(b);
        if (b.last) begin
          foreach (m_pending[i]) exp_q.push_back(m_pending[i]);
          m_committed += m_pending.size();
          m_pending.delete();
          st_inc = 1;
        end
      end
    end
    if (clr) begin
      m_stored = '0; m_dropped = '0;
    end else begin
      m_stored  += 32'(st_inc);
      m_dropped += 32'(dr_inc);
    end
    m_ready = 1'b1;
    @(negedge clk);
    if (tv && rdy) begin
      out_beats++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL out_beat: got unexpected beat %h, required no beat", pre);
      end else begin
        exp_b = exp_q.pop_front();
        if (pre !== exp_b) begin
          n_fail++;
          $display("FAIL out_beat: got %h required %h", pre, exp_b);
        end
      end
    end
    if (tv && !rdy) begin
      n_checks++;
      if (m_tvalid !== 1'b1 || cur_out() !== pre) begin
        n_fail++;
        $display("FAIL hold: got valid=%b %h required valid=1 %h", m_tvalid, cur_out(), pre);
      end
    end
    n_checks++;
    if (m_tvalid !== m_valid) begin
      n_fail++;
      $display("FAIL tvalid: got %b required %b", m_tvalid, m_valid);
    end
    n_checks++;
    if (s_tready !== 1'b1) begin
      n_fail++;
      $display("FAIL s_tready: got %b required 1", s_tready);
    end
    n_checks++;
    if (stored_cnt !== m_stored || dropped_cnt !== m_dropped) begin
      n_fail++;
      $display("FAIL counters: got stored=%0d dropped=%0d required stored=%0d dropped=%0d",
               stored_cnt, dropped_cnt, m_stored, m_dropped);
    end
    n_checks++;
    if (fifo_words !== 7'(m_committed)) begin
      n_fail++;
      $display("FAIL fifo_words: got %0d required %0d", fifo_words, m_committed);
    end
  endtask

  task automatic idle(input int n, input logic rdy, input logic clr);
    beat_t z = '0;
    for (int i = 0; i < n; i++) step(1'b0, z, rdy, clr);
  endtask

  // mode: 0 ready low, 1 ready high, 2 toggle each cycle, 3 random
  task automatic send_packet(input int len, input logic [127:0] user, input int mode,
                             input logic clr_on_last);
    logic rdy;
    for (int i = 0; i < len; i++) begin
      toggle_rdy = ~toggle_rdy;
      case (mode)
        0:       rdy = 1'b0;
        1:       rdy = 1'b1;
        2:       rdy = toggle_rdy;
        default: rdy = ($urandom_range(3) != 0);
      endcase
      step(1'b1, mk_beat(i, len, user), rdy, clr_on_last && (i == len - 1));
    end
  endtask

  task automatic drain();
    int guard = 0;
    while ((exp_q.size() != 0 || m_tvalid) && guard < 300) begin
      idle(1, 1'b1, 1'b0);
      guard++;
    end
    n_checks++;
    if (exp_q.size() != 0 || m_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d beats pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tstrb = '0; s_tuser = '0; s_tlast = 1'b0;
    m_tready = 1'b0; clear_counters = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if (m_tvalid !== 1'b0 || s_tready !== 1'b0 || cur_out() !== '0 || stored_cnt !== 0 ||
        dropped_cnt !== 0 || fifo_words !== 0) begin
      n_fail++;
      $display("FAIL reset_state: got tvalid=%b tready=%b stored=%0d dropped=%0d words=%0d required all 0",
               m_tvalid, s_tready, stored_cnt, dropped_cnt, fifo_words);
    end
    rst_n = 1'b1;
    idle(2, 1'b1, 1'b0);
    $display("test_reset done");
  endtask

  task automatic test_single_packet();
    out_beats = 0;
    send_packet(34, 128'h0201AAAA, 1, 1'b0);
    n_checks++;
    if (m_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_early: got tvalid=%b required 0 one edge after tlast", m_tvalid);
    end
    idle(1, 1'b1, 1'b0);
    n_checks++;
    if (m_tvalid !== 1'b1 || m_tuser !== 128'h0201AAAA) begin
      n_fail++;
      $display("FAIL latency: got tvalid=%b tuser=%h required 1 0201aaaa", m_tvalid, m_tuser);
    end
    drain();
    n_checks++;
    if (out_beats != 34 || stored_cnt !== 1) begin
      n_fail++;
      $display("FAIL single_packet: got beats=%0d stored=%0d required 34 1", out_beats, stored_cnt);
    end
    $display("test_single_packet done: %0d beats", out_beats);
  endtask

  task automatic test_back_to_back_full();
    idle(1, 1'b0, 1'b1);
    out_beats = 0;
    send_packet(34, 128'h11, 0, 1'b0);
    n_checks++;
    if (fifo_words !== 7'd34) begin
      n_fail++;
      $display("FAIL words_after_commit: got %0d required 34", fifo_words);
    end
    send_packet(34, 128'h22, 0, 1'b0);
    n_checks++;
    if (stored_cnt !== 1 || dropped_cnt !== 1) begin
      n_fail++;
      $display("FAIL b2b_counts: got stored=%0d dropped=%0d required 1 1", stored_cnt, dropped_cnt);
    end
    drain();
    n_checks++;
    if (out_beats != 34) begin
      n_fail++;
      $display("FAIL b2b_beats: got %0d required 34", out_beats);
    end
    $display("test_back_to_back_full done: %0d beats", out_beats);
  endtask

  task automatic test_oversize();
    idle(1, 1'b1, 1'b1);
    out_beats = 0;
    send_packet(70, 128'h33, 1, 1'b0);
    send_packet(10, 128'h44, 1, 1'b0);
    drain();
    n_checks++;
    if (out_beats != 10 || stored_cnt !== 1 || dropped_cnt !== 1) begin
      n_fail++;
      $display("FAIL oversize: got beats=%0d stored=%0d dropped=%0d required 10 1 1",
               out_beats, stored_cnt, dropped_cnt);
    end
    $display("test_oversize done: %0d beats", out_beats);
  endtask

  task automatic test_toggle_ready();
    out_beats = 0;
    for (int p = 0; p < 5; p++) send_packet(8, 128'(p + 100), 2, 1'b0);
    for (int i = 0; i < 100 && (exp_q.size() != 0 || m_tvalid); i++) begin
      toggle_rdy = ~toggle_rdy;
      idle(1, toggle_rdy, 1'b0);
    end
    drain();
    n_checks++;
    if (out_beats != 40) begin
      n_fail++;
      $display("FAIL toggle_beats: got %0d required 40", out_beats);
    end
    $display("test_toggle_ready done: %0d beats", out_beats);
  endtask

  task automatic test_clear_on_commit();
    out_beats = 0;
    send_packet(6, 128'h55, 0, 1'b1);
    n_checks++;
    if (stored_cnt !== 0 || dropped_cnt !== 0) begin
      n_fail++;
      $display("FAIL clear_priority: got stored=%0d dropped=%0d required 0 0", stored_cnt, dropped_cnt);
    end
    drain();
    n_checks++;
    if (out_beats != 6) begin
      n_fail++;
      $display("FAIL clear_keeps_data: got %0d beats required 6", out_beats);
    end
    $display("test_clear_on_commit done: %0d beats", out_beats);
  endtask

  task automatic test_async_reset();
    send_packet(4, 128'h66, 0, 1'b0);
    send_packet(12, 128'h77, 0, 1'b0);
    n_checks++;
    if (m_tvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_valid: got %b required 1", m_tvalid);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (m_tvalid !== 1'b0 || s_tready !== 1'b0 || stored_cnt !== 0 || dropped_cnt !== 0 ||
        fifo_words !== 0) begin
      n_fail++;
      $display("FAIL async_reset: got tvalid=%b tready=%b stored=%0d dropped=%0d words=%0d required all 0",
               m_tvalid, s_tready, stored_cnt, dropped_cnt, fifo_words);
    end
    s_tvalid = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(1, 1'b1, 1'b0);
    out_beats = 0;
    send_packet(34, 128'h88, 1, 1'b0);
    drain();
    n_checks++;
    if (out_beats != 34 || stored_cnt !== 1) begin
      n_fail++;
      $display("FAIL after_reset: got beats=%0d stored=%0d required 34 1", out_beats, stored_cnt);
    end
    $display("test_async_reset done: %0d beats", out_beats);
  endtask

  task automatic test_random();
    out_beats = 0;
    for (int p = 0; p < 40; p++) begin
      send_packet($urandom_range(70, 1), 128'($urandom), 3, 1'b0);
      idle($urandom_range(3), ($urandom_range(3) != 0), ($urandom_range(30) == 0));
    end
    drain();
    $display("test_random done: %0d beats, stored=%0d dropped=%0d", out_beats, stored_cnt, dropped_cnt);
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_back_to_back_full();
    test_oversize();
    test_toggle_ready();
    test_clear_on_commit();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
